// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared vehicle-state types and limits for the dashboard
package car_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        RUN    = 2'd1,
        EMPTY  = 2'd2,
        REFUEL = 2'd3
    } car_state_t;

    localparam logic [7:0]  FUEL_MAX     = 8'd100;
    localparam logic [31:0] ODO_MAX      = 32'd99_999;
    localparam logic [7:0]  LOW_FUEL_LVL = 8'd15;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronises a raw button and accepts a new level
// only after it has been stable for STABLE_TICKS consecutive ticks
module btn_debounce #(
    parameter int unsigned STABLE_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [15:0] CNT_LAST = 16'(STABLE_TICKS - 1);

    logic [1:0]  sync;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= 16'd0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            // Any return to the accepted level restarts the stability window
            if (sync[1] == level) begin
                cnt <= 16'd0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    rise  <= sync[1];
                    fall  <= ~sync[1];
                    cnt   <= 16'd0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/odo_fuel_tracker.sv
// rtl/odo_fuel_tracker.sv - integrates speed into odometer km, models fuel
// burn and refuelling, and synchronises the side-brake switch
module odo_fuel_tracker
    import car_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000,
    parameter int unsigned DIST_THRESH = 3_600_000,
    parameter int unsigned FUEL_THRESH = 2_000_000,
    parameter int unsigned IDLE_BURN   = 20,
    parameter int unsigned REFUEL_MS   = 100,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned ODO_INIT    = 0,
    parameter int unsigned FUEL_INIT   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        engine_on,
    input  logic [7:0]  speed,
    input  logic        refuel_btn,
    input  logic        side_brake_sw,
    output logic [31:0] odometer,
    output logic [7:0]  fuel,
    output logic        is_side_brake,
    output logic        low_fuel,
    output logic        fuel_empty,
    output logic        refueling
);

    localparam logic [15:0] REF_LAST = 16'(REFUEL_MS - 1);

    car_state_t  state, state_next;
    logic [31:0] pre_cnt;
    logic        tick;
    logic [31:0] dist_acc, dist_sum;
    logic [31:0] burn_acc, burn_sum;
    logic [15:0] ref_cnt;
    logic        engine_q;
    logic [1:0]  brake_sync;
    logic        btn_level, btn_rise, btn_fall;
    logic        press, release_btn, engine_rise;

    btn_debounce #(.STABLE_TICKS(DEBOUNCE_MS)) u_refuel_db (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (refuel_btn),
        .level (btn_level),
        .rise  (btn_rise),
        .fall  (btn_fall)
    );

    assign tick        = (pre_cnt == TICK_DIV - 1);
    assign dist_sum    = dist_acc + {24'd0, speed};
    assign burn_sum    = burn_acc + IDLE_BURN + {24'd0, speed};
    assign press       = btn_rise & ~engine_on;
    assign release_btn = btn_fall | ~btn_level;
    assign engine_rise = engine_on & ~engine_q;

    assign is_side_brake = brake_sync[1];
    assign low_fuel      = (fuel < LOW_FUEL_LVL);
    assign fuel_empty    = (fuel == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            pre_cnt    <= 32'd0;
            dist_acc   <= 32'd0;
            burn_acc   <= 32'd0;
            ref_cnt    <= 16'd0;
            odometer   <= 32'(ODO_INIT);
            fuel       <= 8'(FUEL_INIT);
            engine_q   <= 1'b0;
            brake_sync <= 2'b00;
        end else begin
            state      <= state_next;
            pre_cnt    <= tick ? 32'd0 : pre_cnt + 32'd1;
            engine_q   <= engine_on;
            brake_sync <= {brake_sync[0], side_brake_sw};

            if (tick) begin
                if (dist_sum >= DIST_THRESH) begin
                    dist_acc <= dist_sum - DIST_THRESH;
                    odometer <= (odometer == ODO_MAX) ? 32'd0 : odometer + 32'd1;
                end else begin
                    dist_acc <= dist_sum;
                end
            end

            // Burn in RUN and refuel cadence in REFUEL are mutually exclusive
            if (tick && state == RUN) begin
                if (fuel == 8'd0) begin
                    burn_acc <= 32'd0;
                end else if (burn_sum >= FUEL_THRESH) begin
                    fuel     <= fuel - 8'd1;
                    burn_acc <= (fuel == 8'd1) ? 32'd0 : burn_sum - FUEL_THRESH;
                end else begin
                    burn_acc <= burn_sum;
                end
            end else if (tick && state == REFUEL && ref_cnt == REF_LAST && fuel < FUEL_MAX) begin
                fuel <= fuel + 8'd1;
            end

            if (state != REFUEL) begin
                ref_cnt <= 16'd0;
            end else if (tick) begin
                ref_cnt <= (ref_cnt == REF_LAST) ? 16'd0 : ref_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        refueling  = 1'b0;
        case (state)
            OFF: begin
                if (engine_on)
                    state_next = RUN;
                else if (press && fuel < FUEL_MAX)
                    state_next = REFUEL;
            end
            RUN: begin
                if (!engine_on)
                    state_next = OFF;
                else if (fuel == 8'd0)
                    state_next = EMPTY;
            end
            EMPTY: begin
                if (press)
                    state_next = REFUEL;
            end
            REFUEL: begin
                refueling = 1'b1;
                if (engine_rise)
                    state_next = RUN;
                else if (fuel == FUEL_MAX || release_btn)
                    state_next = OFF;
            end
            default: state_next = OFF;
        endcase
    end

endmodule

// File: tb/tb_odo_fuel_tracker.sv
// tb/tb_odo_fuel_tracker.sv - directed vectors for odo_fuel_tracker with
// scaled-down timing; a second instance covers the odometer-wrap and empty-tank cases
module tb_odo_fuel_tracker;
    import car_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        engine_on = 1'b0, refuel_btn = 1'b0, side_brake_sw = 1'b0;
    logic [7:0]  speed = 8'd0;
    logic [31:0] odometer;
    logic [7:0]  fuel;
    logic        is_side_brake, low_fuel, fuel_empty, refueling;

    logic        engine_on_b = 1'b0, refuel_btn_b = 1'b0, side_brake_sw_b = 1'b0;
    logic [7:0]  speed_b = 8'd0;
    logic [31:0] odometer_b;
    logic [7:0]  fuel_b;
    logic        is_side_brake_b, low_fuel_b, fuel_empty_b, refueling_b;

    int n_vec = 0;
    int n_err = 0;
    int ref_entries = 0;
    logic ref_prev = 1'b0;

    always #5 clk = ~clk;

    odo_fuel_tracker #(
        .TICK_DIV(10), .DIST_THRESH(100), .FUEL_THRESH(50), .IDLE_BURN(5),
        .REFUEL_MS(3), .DEBOUNCE_MS(2), .ODO_INIT(0), .FUEL_INIT(100)
    ) dut (
        .clk(clk), .rst(rst), .engine_on(engine_on), .speed(speed),
        .refuel_btn(refuel_btn), .side_brake_sw(side_brake_sw),
        .odometer(odometer), .fuel(fuel), .is_side_brake(is_side_brake),
        .low_fuel(low_fuel), .fuel_empty(fuel_empty), .refueling(refueling)
    );

    odo_fuel_tracker #(
        .TICK_DIV(10), .DIST_THRESH(100), .FUEL_THRESH(50), .IDLE_BURN(5),
        .REFUEL_MS(3), .DEBOUNCE_MS(2), .ODO_INIT(99_999), .FUEL_INIT(1)
    ) dut_b (
        .clk(clk), .rst(rst), .engine_on(engine_on_b), .speed(speed_b),
        .refuel_btn(refuel_btn_b), .side_brake_sw(side_brake_sw_b),
        .odometer(odometer_b), .fuel(fuel_b), .is_side_brake(is_side_brake_b),
        .low_fuel(low_fuel_b), .fuel_empty(fuel_empty_b), .refueling(refueling_b)
    );

    always @(negedge clk) begin
        if (refueling && !ref_prev)
            ref_entries++;
        ref_prev = refueling;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the clock edge that consumes each tick
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (dut.tick !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100)
                check("tick_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_refuel_a();
        int guard;
        guard = 0;
        while (refueling !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("refuel_entered", 32'(refueling), 32'd1);
    endtask

    task automatic wait_refuel_b();
        int guard;
        guard = 0;
        while (refueling_b !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("b_refuel_entered", 32'(refueling_b), 32'd1);
    endtask

    initial begin
        logic [4:0] bounce;
        bounce = 5'b10101;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_odo", odometer, 32'd0);
        check("rst_fuel", 32'(fuel), 32'd100);
        check("rst_brake", 32'(is_side_brake), 32'd0);
        check("rst_low", 32'(low_fuel), 32'd0);
        check("rst_empty", 32'(fuel_empty), 32'd0);
        check("rst_refueling", 32'(refueling), 32'd0);
        check("rst_state", 32'(dut.state), 32'(OFF));
        check("b_rst_odo", odometer_b, 32'd99_999);
        check("b_rst_fuel", 32'(fuel_b), 32'd1);
        check("b_rst_low", 32'(low_fuel_b), 32'd1);
        check("b_rst_empty", 32'(fuel_empty_b), 32'd0);

        // 10 ticks at 20 km/h: 200 speed-ms -> 2 km, 250 burn -> 5 %
        wait_ticks(1);
        engine_on = 1'b1;
        speed     = 8'd20;
        wait_ticks(10);
        check("run_odo", odometer, 32'd2);
        check("run_fuel", 32'(fuel), 32'd95);
        check("run_dist_acc", dut.dist_acc, 32'd0);
        check("run_burn_acc", dut.burn_acc, 32'd0);
        check("run_state", 32'(dut.state), 32'(RUN));

        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check("mid_rst_odo", odometer, 32'd0);
        check("mid_rst_fuel", 32'(fuel), 32'd100);
        check("mid_rst_state", 32'(dut.state), 32'(OFF));
        check("mid_rst_refueling", 32'(refueling), 32'd0);
        engine_on = 1'b0;
        speed     = 8'd0;
        @(negedge clk);
        rst = 1'b0;

        // 6 ticks at 20 km/h: 150 burn -> 97 %, 120 speed-ms -> 1 km
        wait_ticks(1);
        engine_on = 1'b1;
        speed     = 8'd20;
        wait_ticks(6);
        check("pre_refuel_fuel", 32'(fuel), 32'd97);
        check("pre_refuel_odo", odometer, 32'd1);
        engine_on = 1'b0;
        speed     = 8'd0;
        wait_ticks(1);

        for (int i = 4; i >= 0; i--) begin
            refuel_btn = bounce[i];
            cycles(2);
        end
        wait_refuel_a();
        wait_ticks(3);
        check("refuel_fuel_3", 32'(fuel), 32'd98);
        wait_ticks(5);
        check("refuel_fuel_8", 32'(fuel), 32'd99);
        wait_ticks(1);
        check("refuel_fuel_9", 32'(fuel), 32'd100);
        check("refuel_still_on", 32'(refueling), 32'd1);
        cycles(1);
        check("refuel_done", 32'(refueling), 32'd0);
        check("refuel_done_state", 32'(dut.state), 32'(OFF));
        check("refuel_entries", 32'(ref_entries), 32'd1);
        refuel_btn = 1'b0;

        side_brake_sw = 1'b1;
        cycles(1);
        check("brake_on_1cyc", 32'(is_side_brake), 32'd0);
        cycles(1);
        check("brake_on_2cyc", 32'(is_side_brake), 32'd1);
        side_brake_sw = 1'b0;
        cycles(1);
        check("brake_off_1cyc", 32'(is_side_brake), 32'd1);
        cycles(1);
        check("brake_off_2cyc", 32'(is_side_brake), 32'd0);

        // Second instance: odometer wrap with the engine off
        wait_ticks(1);
        speed_b = 8'd100;
        wait_ticks(1);
        check("b_odo_wrap", odometer_b, 32'd0);

        // 5 + 45 burns exactly the last percent in one tick
        speed_b     = 8'd45;
        engine_on_b = 1'b1;
        wait_ticks(1);
        check("b_fuel_zero", 32'(fuel_b), 32'd0);
        check("b_fuel_empty", 32'(fuel_empty_b), 32'd1);
        check("b_low_fuel", 32'(low_fuel_b), 32'd1);
        cycles(1);
        check("b_state_empty", 32'(dut_b.state), 32'(EMPTY));
        wait_ticks(10);
        check("b_fuel_stays_zero", 32'(fuel_b), 32'd0);
        check("b_still_empty", 32'(dut_b.state), 32'(EMPTY));

        engine_on_b  = 1'b0;
        speed_b      = 8'd0;
        refuel_btn_b = 1'b1;
        wait_refuel_b();
        wait_ticks(3);
        check("b_refuel_fuel", 32'(fuel_b), 32'd1);
        engine_on_b = 1'b1;
        cycles(1);
        check("b_abort_state", 32'(dut_b.state), 32'(RUN));
        check("b_abort_refueling", 32'(refueling_b), 32'd0);
        check("b_abort_fuel_kept", 32'(fuel_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/odo_fuel_tracker.md
# odo_fuel_tracker

Vehicle-state source for the dashboard LCD. The block integrates vehicle speed into a kilometre odometer and models fuel burn and refuelling, along with a synchronised side-brake flag. It drives the `odometer`, `fuel` and `is_side_brake` inputs of the LCD controller directly. It sits between the drivetrain/speed model and the display, in the same 50 MHz clock domain.

## Interface
- `TICK_DIV`, 50_000: clk cycles per 1 ms base tick.
- `DIST_THRESH`, 3_600_000: speed·ms units per 1 km (km/h × ms).
- `FUEL_THRESH`, 2_000_000: burn units per 1 % fuel.
- `IDLE_BURN`, 20: burn units added per tick while the engine runs, independent of speed.
- `REFUEL_MS`, 100: ms per +1 % while refuelling.
- `DEBOUNCE_MS`, 20: stable time required on `refuel_btn`.
- `ODO_INIT`, 0: odometer reset value.
- `FUEL_INIT`, 100: fuel reset value.
- `clk` input 1: system clock. One clock.
- `rst` input 1: reset, asynchronous, active-high.
- `engine_on` input 1: engine running (synchronous to clk).
- `speed` input 8: vehicle speed, km/h, 0–255.
- `refuel_btn` input 1: raw pushbutton, asynchronous and bouncing.
- `side_brake_sw` input 1: raw switch, asynchronous.
- `odometer` output 32: km, range 0–99_999.
- `fuel` output 8: percent, range 0–100.
- `is_side_brake` output 1: synchronised side-brake state.
- `low_fuel` output 1: high when `fuel` < 15.
- `fuel_empty` output 1: high when `fuel` == 0.
- `refueling` output 1: high while in REFUEL.

## Operation
**Tick prescaler**
- Counter runs 0..TICK_DIV-1.
- `tick` pulses for one cycle at wrap.

**Distance path**
- On `tick`: `dist_acc += speed`.
- If the new `dist_acc` ≥ DIST_THRESH: `dist_acc -= DIST_THRESH` (remainder kept) and `odometer` increments.
- `odometer` wraps 99_999 → 0.
- Distance accumulates whenever `speed` > 0, in any state.

**Fuel path** (RUN only)
- On `tick`: `burn_acc += IDLE_BURN + speed`.
- At ≥ FUEL_THRESH: subtract the threshold and decrement `fuel`.
- `fuel` saturates at 0; at 0, `burn_acc` clears.

**Accumulator width**
- `dist_acc` and `burn_acc` are 32 bits unsigned, with no overflow for any legal parameter.

**FSM states**
- **OFF**: `engine_on` = 0, no burn.
  - `engine_on` = 1 → RUN.
  - Debounced press with `fuel` < 100 → REFUEL.
- **RUN**: burning.
  - `engine_on` = 0 → OFF.
  - `fuel` reaches 0 → EMPTY.
- **EMPTY**: no burn, `fuel_empty` = 1.
  - Debounced press while `engine_on` = 0 → REFUEL.
- **REFUEL**: `refueling` = 1; `fuel` +1 every REFUEL_MS ticks.
  - `fuel` = 100, or debounced button release → OFF.
  - `engine_on` rising → RUN. Abort; fuel already added is kept.

**Side brake**
- 2-FF synchroniser.
- `is_side_brake` = second flop.

**Simultaneous events**
- A tick that crosses both thresholds updates `odometer` and `fuel` in the same cycle.
- In REFUEL, the refuel increment and the odometer increment may coincide.
- Refuel presses are ignored while `engine_on` = 1.

## Timing
**Reset values**
- Outputs: `odometer` = ODO_INIT, `fuel` = FUEL_INIT, `is_side_brake` = 0, `low_fuel` = (FUEL_INIT < 15), `fuel_empty` = (FUEL_INIT == 0), `refueling` = 0.
- Internal: state OFF, both accumulators 0, prescaler 0, refuel counter 0, debouncer cleared.
- Mid-operation reset: immediate (asynchronous) return to the above; accumulator remainders are lost.

**Update latency**
- `odometer` and `fuel` update on the clk edge that ends the `tick` cycle (1 cycle).
- `low_fuel` and `fuel_empty` are decoded from registered `fuel` (combinational, glitch-free).
- `speed` is sampled only on `tick`. Changes between ticks take effect at the next tick.

**Input latency**
- `is_side_brake`: 2 cycles after `side_brake_sw` changes.
- Refuel press is recognised after 2-cycle sync plus DEBOUNCE_MS consecutive stable ticks.

**Refuel cadence**
- The first +1 occurs REFUEL_MS ticks after REFUEL is entered.
- The refuel counter resets on state entry.

## Structure
**Shared package `car_pkg`**
- FSM state enum (OFF, RUN, EMPTY, REFUEL).
- Constants FUEL_MAX = 100, ODO_MAX = 99_999, LOW_FUEL_LVL = 15.
- The LCD block reuses the same `low_fuel` threshold from this package.

**Sub-module `btn_debounce`**
- 2-FF synchroniser, tick-driven stability counter, outputs `level`, `rise`, `fall`.
- Used for `refuel_btn`. Reusable for other dashboard buttons.

## Test plan
Bench parameters for all scenarios: TICK_DIV = 10, DIST_THRESH = 100, FUEL_THRESH = 50, IDLE_BURN = 5, REFUEL_MS = 3, DEBOUNCE_MS = 2.
1. Reset mid-run (e.g. `odometer` = 7, `fuel` = 80) → next cycle `odometer` = 0, `fuel` = 100, state OFF, `refueling` = 0.
2. `engine_on` = 1, `speed` = 20 for 10 ticks → `odometer` = 2, and `fuel` = 95 (burn 25/tick gives exactly 5 %); `dist_acc` and `burn_acc` both 0.
3. Preload `odometer` = 99_999, `speed` = 100, 1 tick → `odometer` = 0.
4. `fuel` = 1, `engine_on` = 1, `speed` = 45 → after 1 tick `fuel` = 0, `fuel_empty` = 1, state EMPTY; a further 10 ticks leave `fuel` at 0.
5. Engine off, `fuel` = 97, hold `refuel_btn` with 5 bounce edges → single REFUEL entry; `fuel` reaches 100 after 9 ticks, then state OFF.
6. In REFUEL, assert `engine_on` → state RUN next cycle with `fuel` retained; toggle `side_brake_sw` → `is_side_brake` follows 2 cycles later.
